// File: rtl/acorn128_host_if.sv
// rtl/acorn128_host_if.sv - word-serial host front end for acorn128_top (optional ACORN_IF_TIMEOUT_EN run timeout)
module acorn128_host_if #(
    parameter int TIMEOUT_CYCLES = 8192
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [31:0]  s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [31:0]  m_data,
    output logic         m_last,
    output logic         core_rst,
    output logic         core_start,
    output logic         core_encrypt,
    output logic [127:0] core_key,
    output logic [127:0] core_iv,
    output logic [127:0] core_ad,
    output logic [127:0] core_pt,
    output logic [63:0]  core_len,
    input  logic [127:0] core_ct,
    input  logic [127:0] core_tag,
    input  logic         core_ready,
    output logic         busy,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        RECOVER
    } state_t;

    state_t         state;
    // All load fields in arrival order; words enter at the bottom so the
    // first (most significant key) word ends up at the top after 18 shifts.
    logic [575:0]   fields;
    logic [255:0]   shreg;
    logic [4:0]     word_cnt;
    logic [2:0]     out_cnt;
    logic           rec_cnt;

`ifdef ACORN_IF_TIMEOUT_EN
    logic [15:0]    run_cnt;
    localparam logic [15:0] RUN_LIMIT = 16'(TIMEOUT_CYCLES - 1);
`else
    logic           unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign err        = 1'b0;
`endif

    assign core_key = fields[575:448];
    assign core_iv  = fields[447:320];
    assign core_ad  = fields[319:192];
    assign core_pt  = fields[191:64];
    assign core_len = fields[63:0];
    assign m_data   = shreg[255:224];
    assign busy     = (state != IDLE);

    // Control FSM: load, run the core, drain results, then pulse core reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fields       <= '0;
            shreg        <= '0;
            word_cnt     <= '0;
            out_cnt      <= '0;
            rec_cnt      <= 1'b0;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            core_start   <= 1'b0;
            core_encrypt <= 1'b0;
            core_rst     <= 1'b1;
`ifdef ACORN_IF_TIMEOUT_EN
            run_cnt      <= '0;
            err          <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    core_rst <= 1'b0;
                    s_ready  <= 1'b1;
                    if (s_valid && s_ready) begin
                        fields   <= {fields[543:0], s_data};
                        word_cnt <= 5'd1;
                        state    <= LOAD;
`ifdef ACORN_IF_TIMEOUT_EN
                        err      <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        fields <= {fields[543:0], s_data};
                        if (word_cnt == 5'd17) begin
                            word_cnt     <= '0;
                            s_ready      <= 1'b0;
                            core_start   <= 1'b1;
                            core_encrypt <= 1'b1;
                            state        <= RUN;
`ifdef ACORN_IF_TIMEOUT_EN
                            run_cnt      <= '0;
`endif
                        end else begin
                            word_cnt <= word_cnt + 5'd1;
                        end
                    end
                end
                RUN: begin
                    if (core_ready) begin
                        shreg        <= {core_ct, core_tag};
                        out_cnt      <= '0;
                        m_valid      <= 1'b1;
                        m_last       <= 1'b0;
                        core_start   <= 1'b0;
                        core_encrypt <= 1'b0;
                        state        <= DRAIN;
`ifdef ACORN_IF_TIMEOUT_EN
                    end else if (run_cnt == RUN_LIMIT) begin
                        err          <= 1'b1;
                        core_start   <= 1'b0;
                        core_encrypt <= 1'b0;
                        core_rst     <= 1'b1;
                        rec_cnt      <= 1'b0;
                        state        <= RECOVER;
                    end else begin
                        run_cnt <= run_cnt + 16'd1;
`endif
                    end
                end
                DRAIN: begin
                    if (m_valid && m_ready) begin
                        shreg   <= {shreg[223:0], 32'h0};
                        out_cnt <= out_cnt + 3'd1;
                        m_last  <= (out_cnt == 3'd6);
                        if (out_cnt == 3'd7) begin
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            core_rst <= 1'b1;
                            rec_cnt  <= 1'b0;
                            state    <= RECOVER;
                        end
                    end
                end
                RECOVER: begin
                    if (rec_cnt) begin
                        core_rst <= 1'b0;
                        s_ready  <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        rec_cnt <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acorn128_host_if.sv
// tb/tb_acorn128_host_if.sv - randomized self-checking bench for acorn128_host_if
module tb_acorn128_host_if;

`ifdef ACORN_IF_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 8192;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data;
    logic         m_last;
    logic         core_rst, core_start, core_encrypt;
    logic [127:0] core_key, core_iv, core_ad, core_pt;
    logic [63:0]  core_len;
    logic [127:0] core_ct = '0;
    logic [127:0] core_tag = '0;
    logic         core_ready = 1'b0;
    logic         busy, err;

    int checks = 0;
    int errors = 0;
    logic [31:0] words [18];

    always #5 clk = ~clk;

    acorn128_host_if #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .core_rst(core_rst), .core_start(core_start), .core_encrypt(core_encrypt),
        .core_key(core_key), .core_iv(core_iv), .core_ad(core_ad), .core_pt(core_pt),
        .core_len(core_len), .core_ct(core_ct), .core_tag(core_tag),
        .core_ready(core_ready), .busy(busy), .err(err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; core_ready = 1'b0;
        repeat (cycles) step();
        check("rst_core_rst", core_rst, 1);
        check("rst_s_ready", s_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_start", core_start, 0);
        check("rst_encrypt", core_encrypt, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_key", core_key, 0);
        check("rst_len", core_len, 0);
        rst = 1'b0;
        step();
        check("rel_core_rst", core_rst, 0);
        check("rel_s_ready", s_ready, 1);
    endtask

    task automatic make_words(input bit fixed);
        for (int i = 0; i < 18; i++) words[i] = $urandom;
        if (fixed) begin
            for (int i = 0; i < 4; i++) begin
                logic [7:0] b;
                b = 8'(4 * i);
                words[i]     = {b, b + 8'd1, b + 8'd2, b + 8'd3};
                words[4 + i] = {b + 8'h10, b + 8'h11, b + 8'h12, b + 8'h13};
                words[8 + i] = 32'hA5A5A5A5;
                words[12 + i] = 32'h5A5A5A5A;
            end
            words[16] = 32'h0;
            words[17] = 32'h80;
        end
    endtask

    task automatic load(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_valid = 1'b1;
            s_data  = words[i];
            while (!s_ready && guard < 50) begin
                step();
                guard++;
            end
            if (!s_ready) begin
                check("s_ready_wait", s_ready, 1);
                s_valid = 1'b0;
                return;
            end
            if (i == 17) check("start_before_last", core_start, 0);
            step();
            s_valid = 1'b0;
            if (toggle && i < n - 1) step();
        end
    endtask

    task automatic check_loaded();
        check("start_after_load", core_start, 1);
        check("encrypt_after_load", core_encrypt, 1);
        check("s_ready_run", s_ready, 0);
        check("busy_run", busy, 1);
        check("key", core_key, {words[0], words[1], words[2], words[3]});
        check("iv", core_iv, {words[4], words[5], words[6], words[7]});
        check("ad", core_ad, {words[8], words[9], words[10], words[11]});
        check("pt", core_pt, {words[12], words[13], words[14], words[15]});
        check("len", core_len, {words[16], words[17]});
    endtask

    // Runs the core stub then drains; abort_at >= 0 asserts rst while that word is pending.
    task automatic run_and_drain(input bit stall, input bit rand_ready, input int abort_at);
        logic [31:0] exp [8];
        logic [31:0] held = '0;
        bit   stalled = 1'b0;
        int   got = 0;
        int   guard = 0;
        int   stall_cnt = 0;
        int   wait_cyc = $urandom_range(0, 4);
        for (int i = 0; i < 4; i++) begin
            exp[i]     = core_ct[127 - 32 * i -: 32];
            exp[4 + i] = core_tag[127 - 32 * i -: 32];
        end
        repeat (wait_cyc) step();
        check("run_no_m_valid", m_valid, 0);
        check("run_start_held", core_start, 1);
        core_ready = 1'b1;
        step();
        core_ready = 1'b0;
        check("m_valid_latency", m_valid, 1);
        check("drain_start_low", core_start, 0);
        while (got < 8 && guard < 200) begin
            bit r;
            guard++;
            if (got == abort_at) begin
                rst = 1'b1;
                step();
                step();
                rst = 1'b0;
                step();
                check("abort_m_valid", m_valid, 0);
                check("abort_busy", busy, 0);
                repeat (4) step();
                check("abort_no_output", m_valid, 0);
                return;
            end
            if (stall && got == 3 && stall_cnt < 5) begin
                r = 1'b0;
                stall_cnt++;
            end else if (rand_ready) r = 1'($urandom_range(0, 1));
            else r = 1'b1;
            if (!m_valid) begin
                check("m_valid_during_drain", m_valid, 1);
                break;
            end
            if (stalled) check("m_data_stable", m_data, held);
            check("m_data", m_data, exp[got]);
            check("m_last", m_last, (got == 7));
            m_ready = r;
            held    = m_data;
            stalled = !r;
            if (r) got++;
            step();
        end
        m_ready = 1'b0;
        check("word_count", got, 8);
        check("rec1_m_valid", m_valid, 0);
        check("rec1_core_rst", core_rst, 1);
        check("rec1_s_ready", s_ready, 0);
        step();
        check("rec2_core_rst", core_rst, 1);
        step();
        check("idle_core_rst", core_rst, 0);
        check("idle_s_ready", s_ready, 1);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        do_reset(3);

        // Fixed vector, fixed ct/tag, m_ready always high.
        make_words(1'b1);
        load(18, 1'b0);
        check_loaded();
        check("key_const", core_key, 128'h000102030405060708090A0B0C0D0E0F);
        check("iv_const", core_iv, 128'h101112131415161718191A1B1C1D1E1F);
        check("len_const", core_len, 64'h80);
        core_ct  = {4{32'h11111111}};
        core_tag = {4{32'h22222222}};
        run_and_drain(1'b0, 1'b0, -1);

        // Toggled s_valid plus a 5-cycle stall mid-drain.
        make_words(1'b0);
        load(18, 1'b1);
        check_loaded();
        core_ct  = {$urandom, $urandom, $urandom, $urandom};
        core_tag = {$urandom, $urandom, $urandom, $urandom};
        run_and_drain(1'b1, 1'b0, -1);

        // Reset at word 9 of load.
        make_words(1'b0);
        load(9, 1'b0);
        check("partial_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        check("midload_busy", busy, 0);
        check("midload_key_cleared", core_key, 0);
        check("midload_m_valid", m_valid, 0);

        // Reset during DRAIN word 3.
        make_words(1'b0);
        load(18, 1'b0);
        check_loaded();
        core_ct  = {$urandom, $urandom, $urandom, $urandom};
        core_tag = {$urandom, $urandom, $urandom, $urandom};
        run_and_drain(1'b0, 1'b0, 2);

        // Random transactions with random backpressure.
        for (int t = 0; t < 3; t++) begin
            make_words(1'b0);
            load(18, 1'($urandom_range(0, 1)));
            check_loaded();
            core_ct  = {$urandom, $urandom, $urandom, $urandom};
            core_tag = {$urandom, $urandom, $urandom, $urandom};
            run_and_drain(1'b0, 1'b1, -1);
        end

`ifdef ACORN_IF_TIMEOUT_EN
        make_words(1'b0);
        load(18, 1'b0);
        check_loaded();
        repeat (15) step();
        check("to_err_early", err, 0);
        check("to_start_early", core_start, 1);
        step();
        check("to_err", err, 1);
        check("to_start_low", core_start, 0);
        check("to_core_rst1", core_rst, 1);
        check("to_m_valid", m_valid, 0);
        step();
        check("to_core_rst2", core_rst, 1);
        step();
        check("to_idle_busy", busy, 0);
        check("to_err_sticky", err, 1);
        check("to_idle_m_valid", m_valid, 0);
        s_valid = 1'b1;
        s_data  = $urandom;
        step();
        s_valid = 1'b0;
        check("to_err_cleared", err, 0);
        check("to_load_busy", busy, 1);
        do_reset(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
